// File: rtl/iserdes_bitslip_align_pkg.sv
// Shared types and defaults for the ISERDES word aligner.
package iserdes_align_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_SLIP   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_LOCKED = 3'd4,
      ST_FAIL   = 3'd5
   } state_e;

   localparam logic [7:0]  TRAIN_PATTERN_DEF = 8'h5C;
   localparam int unsigned SLIP_CNT_W        = 4;

endpackage

// File: rtl/iserdes_bitslip_align_if.sv
// Aligner <-> ISERDES/fabric signal bundle; master is the aligner side.
interface iserdes_bitslip_align_if
   import iserdes_align_pkg::*;
#(
   parameter int unsigned WIDTH = 8
);
   logic                  align_start;
   logic [WIDTH-1:0]      din;
   logic                  bitslip;
   logic                  aligned;
   logic                  align_fail;
   logic [SLIP_CNT_W-1:0] slip_count;
   logic [WIDTH-1:0]      dout;
   logic                  dout_valid;

   modport master (
      input  align_start, din,
      output bitslip, aligned, align_fail, slip_count, dout, dout_valid
   );

   modport slave (
      output align_start, din,
      input  bitslip, aligned, align_fail, slip_count, dout, dout_valid
   );
endinterface

// File: rtl/iserdes_bitslip_align.sv
// ISERDES word aligner: slips the word boundary until TRAIN_PATTERN repeats MATCH_COUNT times.
// Define ISERDES_ALIGN_AUTORETRY_EN to leave FAIL after RETRY_DELAY cycles and search again.
module iserdes_bitslip_align
   import iserdes_align_pkg::*;
#(
   parameter int unsigned      WIDTH         = 8,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(TRAIN_PATTERN_DEF),
   parameter int unsigned      MATCH_COUNT   = 16,
   parameter int unsigned      SLIP_WAIT     = 4,
   parameter int unsigned      RETRY_DELAY   = 1024
) (
   input  logic                             clk,
   input  logic                             rst_n,
   iserdes_bitslip_align_if.master          bus
);

   localparam int unsigned WAIT_W  = $clog2(SLIP_WAIT + 1);
   localparam int unsigned RETRY_W = $clog2(RETRY_DELAY + 1);

   state_e                state_q, state_d;
   logic [WIDTH-1:0]      din_q, din_d;
   logic [7:0]            match_cnt_q, match_cnt_d;
   logic [SLIP_CNT_W-1:0] slip_cnt_q, slip_cnt_d;
   logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic [RETRY_W-1:0]    retry_cnt_q, retry_cnt_d;
   logic                  bitslip_q, bitslip_d;
   logic                  aligned_q, aligned_d;
   logic                  align_fail_q, align_fail_d;
   logic [WIDTH-1:0]      dout_q, dout_d;
   logic                  dout_valid_q, dout_valid_d;

   always_comb begin
      state_d     = state_q;
      din_d       = bus.din;
      match_cnt_d = match_cnt_q;
      slip_cnt_d  = slip_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      retry_cnt_d = retry_cnt_q;

      if (bus.align_start) begin
         state_d     = ST_CHECK;
         match_cnt_d = '0;
         slip_cnt_d  = '0;
         wait_cnt_d  = '0;
         retry_cnt_d = '0;
      end else begin
         case (state_q)
            ST_CHECK: begin
               if (din_q == TRAIN_PATTERN) begin
                  if (match_cnt_q + 8'd1 >= 8'(MATCH_COUNT)) begin
                     match_cnt_d = 8'(MATCH_COUNT);
                     state_d     = ST_LOCKED;
                  end else begin
                     match_cnt_d = match_cnt_q + 8'd1;
                  end
               end else begin
                  match_cnt_d = '0;
                  if (slip_cnt_q == SLIP_CNT_W'(WIDTH)) begin
                     state_d = ST_FAIL;
                  end else begin
                     // count on entry so slip_count rises with the bitslip pulse
                     state_d    = ST_SLIP;
                     slip_cnt_d = slip_cnt_q + 1'b1;
                  end
               end
            end
            ST_SLIP: begin
               state_d    = ST_WAIT;
               wait_cnt_d = '0;
            end
            ST_WAIT: begin
               if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
                  state_d    = ST_CHECK;
                  wait_cnt_d = '0;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
            ST_FAIL: begin
`ifdef ISERDES_ALIGN_AUTORETRY_EN
               if (retry_cnt_q == RETRY_W'(RETRY_DELAY - 1)) begin
                  state_d     = ST_CHECK;
                  retry_cnt_d = '0;
                  match_cnt_d = '0;
                  slip_cnt_d  = '0;
               end else begin
                  retry_cnt_d = retry_cnt_q + 1'b1;
               end
`else
               retry_cnt_d = retry_cnt_q;
`endif
            end
            ST_IDLE, ST_LOCKED: ;
            default: state_d = ST_IDLE;
         endcase
      end

      // Moore outputs decoded from the next state so they line up with state_q
      bitslip_d    = (state_d == ST_SLIP);
      aligned_d    = (state_d == ST_LOCKED);
      align_fail_d = (state_d == ST_FAIL);
      dout_valid_d = (state_d == ST_LOCKED);
      dout_d       = (state_d == ST_LOCKED) ? din_q : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         din_q        <= '0;
         match_cnt_q  <= '0;
         slip_cnt_q   <= '0;
         wait_cnt_q   <= '0;
         retry_cnt_q  <= '0;
         bitslip_q    <= 1'b0;
         aligned_q    <= 1'b0;
         align_fail_q <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         din_q        <= din_d;
         match_cnt_q  <= match_cnt_d;
         slip_cnt_q   <= slip_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         retry_cnt_q  <= retry_cnt_d;
         bitslip_q    <= bitslip_d;
         aligned_q    <= aligned_d;
         align_fail_q <= align_fail_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign bus.bitslip    = bitslip_q;
   assign bus.aligned    = aligned_q;
   assign bus.align_fail = align_fail_q;
   assign bus.slip_count = slip_cnt_q;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_iserdes_bitslip_align.sv
// Directed bench for iserdes_bitslip_align with a bitslip-driven ISERDES word model.
module tb_iserdes_bitslip_align;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   iserdes_bitslip_align_if #(.WIDTH(8)) bus();

   iserdes_bitslip_align #(
      .WIDTH(8), .TRAIN_PATTERN(8'h5C), .MATCH_COUNT(16), .SLIP_WAIT(4), .RETRY_DELAY(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   // ISERDES model: each slip moves the window one serial bit later, i.e. the
   // Q1-MSB word rotates right by one; effect lands 2 cycles after the pulse.
   logic [7:0] base;
   logic [2:0] rot;
   logic       bs_q, rot_clr, model_en, bad;

   function automatic logic [7:0] rotr(input logic [7:0] w, input logic [2:0] n);
      logic [7:0] r;
      r = w;
      for (int i = 0; i < int'(n); i++) r = {r[0], r[7:1]};
      return r;
   endfunction

   always @(posedge clk) begin
      if (rot_clr) begin
         rot  <= 3'd0;
         bs_q <= 1'b0;
      end else begin
         bs_q <= bus.bitslip;
         if (bs_q) rot <= rot + 3'd1;
      end
   end

   assign bus.din = bad ? 8'h00 : (model_en ? rotr(base, rot) : base);

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int pulses = 0;
   int last_bs = 0;
   int min_gap = 1000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance n clocks, sampling at the falling edge and tracking bitslip pulses
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         if (bus.bitslip) begin
            if (pulses > 0 && (cyc - last_bs) < min_gap) min_gap = cyc - last_bs;
            pulses++;
            last_bs = cyc;
         end
      end
   endtask

   task automatic clr_stats();
      pulses  = 0;
      min_gap = 1000;
   endtask

   task automatic start();
      bus.align_start = 1'b1;
      step(1);
      bus.align_start = 1'b0;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; bus.align_start = 1'b0;
      base = 8'h5C; model_en = 1'b1; rot_clr = 1'b1; bad = 1'b0;
      step(3);
      check("rst_bitslip", bus.bitslip, 0);
      check("rst_aligned", bus.aligned, 0);
      check("rst_fail", bus.align_fail, 0);
      check("rst_slips", bus.slip_count, 0);
      check("rst_dout", bus.dout, 0);
      check("rst_dvalid", bus.dout_valid, 0);
      rst_n = 1'b1; rot_clr = 1'b0;
      step(2);
      check("idle_aligned", bus.aligned, 0);

      // T1: already aligned, lock after 16 compares
      clr_stats();
      start();
      step(15);
      check("t1_not_yet", bus.aligned, 0);
      step(1);
      check("t1_aligned", bus.aligned, 1);
      check("t1_dvalid", bus.dout_valid, 1);
      check("t1_dout", bus.dout, 8'h5C);
      check("t1_slips", bus.slip_count, 0);
      check("t1_pulses", pulses, 0);

      // T2: 3-bit offset, slips at E1/E7/E13, lock after E34
      base = 8'hE2; rot_clr = 1'b1;
      step(1);
      rot_clr = 1'b0;
      step(2);
      check("locked_sticky", bus.aligned, 1);
      clr_stats();
      start();
      check("t2_restart_clr", bus.aligned, 0);
      step(1);
      check("t2_first_slip", bus.bitslip, 1);
      check("t2_first_cnt", bus.slip_count, 1);
      step(32);
      check("t2_not_yet", bus.aligned, 0);
      step(1);
      check("t2_aligned", bus.aligned, 1);
      check("t2_slips", bus.slip_count, 3);
      check("t2_pulses", pulses, 3);
      check("t2_min_gap", min_gap, 6);
      check("t2_dout", bus.dout, 8'h5C);

      // T3/T4: no alignment possible, 8 slips then FAIL after E49
      base = 8'h00; rot_clr = 1'b1;
      step(1);
      rot_clr = 1'b0;
      clr_stats();
      start();
      step(48);
      check("t3_fail_early", bus.align_fail, 0);
      step(1);
      check("t3_fail", bus.align_fail, 1);
      check("t3_aligned", bus.aligned, 0);
      check("t3_slips", bus.slip_count, 8);
      check("t3_pulses", pulses, 8);
`ifdef ISERDES_ALIGN_AUTORETRY_EN
      step(31);
      check("t4_fail_hold", bus.align_fail, 1);
      step(1);
      check("t4_fail_clr", bus.align_fail, 0);
      check("t4_slips_clr", bus.slip_count, 0);
      step(1);
      check("t4_reslip", bus.bitslip, 1);
      check("t4_reslip_cnt", bus.slip_count, 1);
`else
      step(2000);
      check("t3_sticky", bus.align_fail, 1);
      check("t3_no_more_slips", pulses, 8);
      check("t3_slips_hold", bus.slip_count, 8);
`endif

      // T5: word 10 of the run corrupted; one slip, then a fresh 16-match run
      base = 8'h5C; model_en = 1'b0;
      step(2);
      clr_stats();
      start();
      step(8);
      bad = 1'b1;
      step(1);
      bad = 1'b0;
      step(1);
      check("t5_slip", bus.bitslip, 1);
      check("t5_slip_cnt", bus.slip_count, 1);
      step(6);
      check("t5_no_early_lock", bus.aligned, 0);
      step(14);
      check("t5_not_yet", bus.aligned, 0);
      step(1);
      check("t5_aligned", bus.aligned, 1);
      check("t5_slips", bus.slip_count, 1);
      check("t5_pulses", pulses, 1);

      // T6: restart while in WAIT, then reset while LOCKED
      base = 8'hE2; model_en = 1'b1; rot_clr = 1'b1;
      step(1);
      rot_clr = 1'b0;
      step(1);
      start();
      step(1);
      check("t6_slip", bus.bitslip, 1);
      step(1);
      start();
      check("t6_no_stray", bus.bitslip, 0);
      check("t6_cnt_clr", bus.slip_count, 0);
      step(1);
      check("t6_fresh_slip_cnt", bus.slip_count, 1);
      n = 0;
      while (bus.aligned !== 1'b1 && n < 200) begin
         step(1);
         n++;
      end
      check("t6_lock", bus.aligned, 1);
      check("t6_slips", bus.slip_count, 2);
      rst_n = 1'b0;
      step(1);
      check("t6_rst_aligned", bus.aligned, 0);
      check("t6_rst_dvalid", bus.dout_valid, 0);
      check("t6_rst_dout", bus.dout, 0);
      check("t6_rst_slips", bus.slip_count, 0);
      check("t6_rst_bitslip", bus.bitslip, 0);
      check("t6_rst_fail", bus.align_fail, 0);
      rst_n = 1'b1;
      step(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
